// File: rtl/midi_msg_tx_if.sv
// Message handshake between the controller logic and the MIDI transmitter.
// One complete MIDI message (status, up to two data bytes, length) per transfer.
interface midi_msg_tx_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;
  logic [1:0] msg_len;

  modport master (output msg_valid, msg_status, msg_data1, msg_data2, msg_len,
                  input  msg_ready);
  modport slave  (input  msg_valid, msg_status, msg_data1, msg_data2, msg_len,
                  output msg_ready);
endinterface

// File: rtl/midi_msg_tx.sv
// MIDI message transmitter: message FIFO, running-status compression and
// 8N1 UART serialisation onto midi_tx.
module midi_msg_tx #(
  parameter int BAUD_CNT_HALF  = 800,
  parameter int FIFO_DEPTH     = 4,
  parameter int RUNNING_STATUS = 1
) (
  input  logic         clk,
  input  logic         rst,
  midi_msg_tx_if.slave msg,
  output logic         midi_tx,
  output logic         busy
);
  localparam int BIT_CYC = 2 * BAUD_CNT_HALF;
  localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [7:0] status;
    logic [6:0] d1;
    logic [6:0] d2;
    logic [1:0] len;
  } entry_t;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  // ---------------- message FIFO ----------------
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_nxt;
  logic          ready_r;
  logic          push, pop;

  assign msg.msg_ready = ready_r;
  assign push = msg.msg_valid && ready_r;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{msg.msg_status, msg.msg_data1, msg.msg_data2, msg.msg_len};
  end

  // ready is derived from the next count so a push can never land on a full FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ready_r <= 1'b1;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count   <= count_nxt;
      ready_r <= (count_nxt != CNT_FULL);
    end
  end

  // ---------------- transmitter ----------------
  state_t          state, state_nxt;
  logic [CW-1:0]   bcnt, bcnt_nxt;
  logic [2:0]      bitn, bitn_nxt;
  logic [1:0]      idx, idx_nxt;
  logic [1:0]      nbytes;
  logic [2:0][7:0] bytes;
  entry_t          w;
  logic [7:0]      rs_val;
  logic            rs_vld;
  logic            tx_nxt;
  logic [7:0]      cur_byte;
  logic            bit_done, more;

  logic            is_chan, is_sys, skip;
  logic [1:0]      load_n;
  logic [2:0][7:0] load_bytes;

  // Byte list for the message in w; bytes[0] goes out first.
  always_comb begin
    is_chan = (w.status < 8'hF0);
    is_sys  = (w.status[7:3] == 5'b11110);
    skip    = (RUNNING_STATUS != 0) && is_chan && rs_vld && (w.status == rs_val);
    if (skip) begin
      load_n     = w.len - 2'd1;
      load_bytes = {8'h00, 1'b0, w.d2, 1'b0, w.d1};
    end else begin
      load_n     = w.len;
      load_bytes = {1'b0, w.d2, 1'b0, w.d1, w.status};
    end
  end

  assign bit_done = (bcnt == BIT_LAST);
  assign more     = ({1'b0, idx} + 3'd1) < {1'b0, nbytes};
  assign busy     = (count != '0) || (state != IDLE);

  always_comb begin
    state_nxt = state;
    bitn_nxt  = bitn;
    idx_nxt   = idx;
    pop       = 1'b0;
    unique case (state)
      IDLE: if (count != '0) begin
        pop       = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        idx_nxt   = 2'd0;
        state_nxt = (w.len != 2'd0 && load_n != 2'd0) ? START : IDLE;
      end
      START: if (bit_done) begin
        bitn_nxt  = 3'd0;
        state_nxt = DATA;
      end
      DATA: if (bit_done) begin
        if (bitn == 3'd7) state_nxt = STOP;
        else              bitn_nxt  = bitn + 3'd1;
      end
      STOP: if (bit_done) begin
        if (more) begin
          idx_nxt   = idx + 2'd1;
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // baud counter restarts on every bit boundary, so there is no drift
    if (state == IDLE || state == LOAD || bit_done) bcnt_nxt = '0;
    else                                           bcnt_nxt = bcnt + 1'b1;

    cur_byte = bytes[idx_nxt];
    unique case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = cur_byte[bitn_nxt];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcnt    <= '0;
      bitn    <= '0;
      idx     <= '0;
      nbytes  <= '0;
      bytes   <= '0;
      w       <= '0;
      rs_val  <= '0;
      rs_vld  <= 1'b0;
      midi_tx <= 1'b1;
    end else begin
      state   <= state_nxt;
      bcnt    <= bcnt_nxt;
      bitn    <= bitn_nxt;
      idx     <= idx_nxt;
      midi_tx <= tx_nxt;
      if (pop) w <= mem[rptr];
      if (state == LOAD && w.len != 2'd0) begin
        bytes  <= load_bytes;
        nbytes <= load_n;
        // real-time statuses leave the running register alone
        if (is_chan && !skip) begin
          rs_val <= w.status;
          rs_vld <= 1'b1;
        end else if (is_sys) begin
          rs_vld <= 1'b0;
        end
      end
    end
  end
endmodule
